// File: rtl/multiplier_seq_nbit.sv
// -----------------------------------------------------------------------------
// multiplier_seq_nbit
//   Sequential N-bit shift-and-add multiplier with unsigned and two's-complement
//   modes. One multiplier bit is consumed per RUN cycle, LSB first, so every
//   operation (including zero operands) takes exactly N RUN cycles.
//   Signed operands are reduced to magnitudes at start; the sign is applied
//   once, when the product is loaded on entry to DONE.
//
// Ports
//   clk          in   1    clock, all state on rising edge
//   rst          in   1    synchronous reset, active-low
//   start        in   1    begin a multiplication (accepted in IDLE or DONE)
//   signed_mode  in   1    1: A/B two's complement, 0: unsigned
//   A            in   N    multiplicand
//   B            in   N    multiplier
//   busy         out  1    high in RUN
//   done         out  1    one-cycle pulse when product/result/overflow update
//   product      out  2N   full product
//   result       out  N    product[N-1:0]
//   overflow     out  1    product does not fit in N bits in the latched mode
// -----------------------------------------------------------------------------
module multiplier_seq_nbit #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product,
    output logic [N-1:0]     result,
    output logic             overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = $clog2(N) + 1;

    logic [1:0]     state_q,    state_d;
    logic [CW-1:0]  cnt_q,      cnt_d;
    logic [2*N-1:0] acc_q,      acc_d;
    logic [2*N-1:0] mcand_q,    mcand_d;
    logic [N-1:0]   mplier_q,   mplier_d;
    logic           neg_q,      neg_d;
    logic           smode_q,    smode_d;
    logic [2*N-1:0] product_q,  product_d;
    logic [N-1:0]   result_q,   result_d;
    logic           overflow_q, overflow_d;

    logic           accept;
    logic           last_run;
    logic [2*N-1:0] acc_sum;
    logic [2*N-1:0] prod_fin;

    // Magnitude of an operand; -2^(N-1) maps to 2^(N-1), which still fits in
    // N unsigned bits.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v,
                                               input logic smode);
        if (smode && v[N-1])
            return (~v) + {{(N-1){1'b0}}, 1'b1};
        return v;
    endfunction

    // hi = product[2N-1:N-1]. Signed fit requires the upper N+1 bits to be a
    // pure sign extension; unsigned fit requires the upper N bits to be zero.
    function automatic logic ovf(input logic [N:0] hi, input logic smode);
        if (smode)
            return !((hi == '0) || (hi == '1));
        return hi[N:1] != '0;
    endfunction

    // start is ignored while RUN is in progress
    assign accept   = start && (state_q != S_RUN);
    assign last_run = (state_q == S_RUN) && (cnt_q == CW'(N - 1));
    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_fin = neg_q ? ('0 - acc_sum) : acc_sum;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        neg_d      = neg_q;
        smode_d    = smode_q;
        product_d  = product_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        if (accept) begin
            // Operands are only looked at here, so later input changes
            // (including unknowns) cannot reach the datapath.
            state_d  = S_RUN;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{N{1'b0}}, magnitude(A, signed_mode)};
            mplier_d = magnitude(B, signed_mode);
            neg_d    = signed_mode && (A[N-1] ^ B[N-1]);
            smode_d  = signed_mode;
        end else begin
            case (state_q)
                S_RUN: begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (last_run) begin
                        state_d    = S_DONE;
                        product_d  = prod_fin;
                        result_d   = prod_fin[N-1:0];
                        overflow_d = ovf(prod_fin[2*N-1:N-1], smode_q);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            neg_q      <= 1'b0;
            smode_q    <= 1'b0;
            product_q  <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            neg_q      <= neg_d;
            smode_q    <= smode_d;
            product_q  <= product_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign product  = product_q;
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_multiplier_seq_nbit.sv
// -----------------------------------------------------------------------------
// tb_multiplier_seq_nbit
//   Directed bench for multiplier_seq_nbit: an N=4 instance driven from a
//   table of hand-computed vectors plus hand-written multi-cycle sequences
//   (reset abort, start while busy, back-to-back start in DONE), and an N=8
//   instance for the 255*255 case.
// -----------------------------------------------------------------------------
module tb_multiplier_seq_nbit;

    localparam int N4 = 4;
    localparam int N8 = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start4, sm4;
    logic [3:0]    a4, b4;
    logic          busy4, done4, ovf4;
    logic [7:0]    prod4;
    logic [3:0]    res4;

    logic          start8, sm8;
    logic [7:0]    a8, b8;
    logic          busy8, done8, ovf8;
    logic [15:0]   prod8;
    logic [7:0]    res8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multiplier_seq_nbit #(.N(N4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .A(a4), .B(b4), .busy(busy4), .done(done4),
        .product(prod4), .result(res4), .overflow(ovf4)
    );

    multiplier_seq_nbit #(.N(N8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .A(a8), .B(b8), .busy(busy8), .done(done8),
        .product(prod8), .result(res8), .overflow(ovf8)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       sm;
        logic [7:0] p;
        logic [3:0] r;
        logic       o;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for done4, starting with the current negedge as the first
    // cycle after the start-sampling edge. lat = cycle index where done is seen
    // (0 if never), busy_cnt = cycles with busy, chg = product changes while busy.
    task automatic wait_done4(input int first_idx, output int lat,
                              output int busy_cnt, output int chg);
        logic [7:0] p0;
        p0 = prod4;
        lat = 0;
        busy_cnt = 0;
        chg = 0;
        for (int i = first_idx; i <= N4 + 6; i++) begin
            if (done4) begin
                lat = i;
                break;
            end
            if (busy4) begin
                busy_cnt++;
                if (prod4 !== p0) chg++;
            end
            @(negedge clk);
        end
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        input logic sm, output int lat, output int busy_cnt,
                        output int chg);
        @(negedge clk);
        start4 = 1'b1; a4 = a; b4 = b; sm4 = sm;
        @(negedge clk);
        // scramble inputs after sampling; they must not matter
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
        wait_done4(1, lat, busy_cnt, chg);
    endtask

    initial begin
        int lat, bc, chg, seen;
        logic [7:0] p_hold;

        vecs[0]  = '{a:4'b0101, b:4'b0010, sm:1'b0, p:8'h0A, r:4'hA, o:1'b0};
        vecs[1]  = '{a:4'b1011, b:4'b0010, sm:1'b0, p:8'h16, r:4'h6, o:1'b1};
        vecs[2]  = '{a:4'b1001, b:4'b0101, sm:1'b1, p:8'hDD, r:4'hD, o:1'b1};
        vecs[3]  = '{a:4'b1111, b:4'b1111, sm:1'b0, p:8'hE1, r:4'h1, o:1'b1};
        vecs[4]  = '{a:4'b1111, b:4'b1111, sm:1'b1, p:8'h01, r:4'h1, o:1'b0};
        vecs[5]  = '{a:4'b1000, b:4'b1000, sm:1'b1, p:8'h40, r:4'h0, o:1'b1};
        vecs[6]  = '{a:4'b0000, b:4'b1011, sm:1'b0, p:8'h00, r:4'h0, o:1'b0};
        vecs[7]  = '{a:4'b0011, b:4'b1110, sm:1'b1, p:8'hFA, r:4'hA, o:1'b0};
        vecs[8]  = '{a:4'b0111, b:4'b0111, sm:1'b1, p:8'h31, r:4'h1, o:1'b1};
        vecs[9]  = '{a:4'b1011, b:4'b0010, sm:1'b1, p:8'hF6, r:4'h6, o:1'b1};
        vecs[10] = '{a:4'b1100, b:4'b0010, sm:1'b1, p:8'hF8, r:4'h8, o:1'b0};
        vecs[11] = '{a:4'b0111, b:4'b0010, sm:1'b0, p:8'h0E, r:4'hE, o:1'b0};

        rst = 1'b0; start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",     32'(busy4), 32'd0);
        chk("reset_done",     32'(done4), 32'd0);
        chk("reset_product",  32'(prod4), 32'd0);
        chk("reset_result",   32'(res4),  32'd0);
        chk("reset_overflow", 32'(ovf4),  32'd0);
        rst = 1'b1;

        // Table-driven vectors
        for (int v = 0; v < 12; v++) begin
            run4(vecs[v].a, vecs[v].b, vecs[v].sm, lat, bc, chg);
            chk($sformatf("v%0d_latency", v),   32'(lat),          32'(N4 + 1));
            chk($sformatf("v%0d_busy_cyc", v),  32'(bc),           32'(N4));
            chk($sformatf("v%0d_run_hold", v),  32'(chg),          32'd0);
            chk($sformatf("v%0d_product", v),   32'(prod4),        32'(vecs[v].p));
            chk($sformatf("v%0d_result", v),    32'(res4),         32'(vecs[v].r));
            chk($sformatf("v%0d_overflow", v),  32'(ovf4),         32'(vecs[v].o));
            chk($sformatf("v%0d_busy_done", v), 32'(busy4),        32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", v), 32'(done4),       32'd0);
            chk($sformatf("v%0d_idle_hold", v),  32'(prod4),       32'(vecs[v].p));
        end

        // Reset aborts a RUN; no done for the aborted operation
        @(negedge clk);
        start4 = 1'b1; a4 = 4'b0101; b4 = 4'b0011; sm4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", 32'(busy4), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy",    32'(busy4), 32'd0);
        chk("abort_product", 32'(prod4), 32'd0);
        chk("abort_done",    32'(done4), 32'd0);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4 || busy4) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run4(4'b0011, 4'b0011, 1'b0, lat, bc, chg);
        chk("after_abort_latency", 32'(lat),   32'(N4 + 1));
        chk("after_abort_product", 32'(prod4), 32'h09);
        chk("after_abort_ovf",     32'(ovf4),  32'd0);

        // start re-pulsed while busy is ignored; then start during DONE
        @(negedge clk);
        start4 = 1'b1; a4 = 4'b0101; b4 = 4'b0011; sm4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        start4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111; sm4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(3, lat, bc, chg);
        chk("ignore_latency",  32'(lat),   32'(N4 + 1));
        chk("ignore_product",  32'(prod4), 32'h0F);
        chk("ignore_overflow", 32'(ovf4),  32'd0);
        p_hold = prod4;
        // still in the DONE cycle: request the next operation
        start4 = 1'b1; a4 = 4'b0110; b4 = 4'b0011; sm4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        chk("b2b_no_idle_busy", 32'(busy4), 32'd1);
        chk("b2b_done_low",     32'(done4), 32'd0);
        chk("b2b_prod_held",    32'(prod4), 32'(p_hold));
        wait_done4(1, lat, bc, chg);
        chk("b2b_latency",  32'(lat),   32'(N4 + 1));
        chk("b2b_run_hold", 32'(chg),   32'd0);
        chk("b2b_product",  32'(prod4), 32'h12);
        chk("b2b_result",   32'(res4),  32'h2);
        chk("b2b_overflow", 32'(ovf4),  32'd1);

        // N=8: 255*255 unsigned
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sm8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        lat = 0;
        for (int i = 1; i <= N8 + 6; i++) begin
            if (done8) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        chk("n8_latency",  32'(lat),   32'(N8 + 1));
        chk("n8_product",  32'(prod8), 32'hFE01);
        chk("n8_result",   32'(res8),  32'h01);
        chk("n8_overflow", 32'(ovf8),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multiplier_seq_nbit.md
MULTIPLIER_SEQ_NBIT -- requirements
Module: multiplier_seq_nbit

Interface
REQ-001 Parameter: N, default 4, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a multiplication; sampled on the rising edge.
REQ-005 signed_mode  input  1  1: A and B are two's complement; 0: A and B are unsigned.
REQ-006 A  input  N  multiplicand.
REQ-007 B  input  N  multiplier.
REQ-008 busy  output  1  high while a multiplication is in progress.
REQ-009 done  output  1  single-cycle pulse when the outputs become valid.
REQ-010 product  output  2N  full-width product.
REQ-011 result  output  N  product[N-1:0].
REQ-012 overflow  output  1  high when the true product does not fit in N bits in the selected mode.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE, with the following transitions:
- IDLE->RUN when start=1.
- RUN->DONE after exactly N RUN cycles.
- DONE->RUN if start=1, otherwise DONE->IDLE.
REQ-014 On the edge that accepts start, the block SHALL latch A, B and signed_mode; input changes after that edge SHALL NOT affect the operation.
REQ-015 In signed mode, the block SHALL latch operand magnitudes (N bits, so -2^(N-1) maps to 2^(N-1)) and a sign bit equal to A[N-1] XOR B[N-1].
REQ-016 Each RUN cycle SHALL process one multiplier bit, LSB first, by shift-and-add into a 2N-bit accumulator.
REQ-017 Latency: done SHALL be high during the cycle that follows the (N+1)th rising edge after the start-sampling edge, for one cycle only.
REQ-018 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-019 On entry to DONE:
- product SHALL be loaded with the accumulator, two's-complement negated when the sign bit is 1 and signed_mode was latched as 1.
- result and overflow SHALL update in the same cycle.
REQ-020 Unsigned overflow SHALL be 1 iff product[2N-1:N] != 0.
REQ-021 Signed overflow SHALL be 1 iff product[2N-1:N-1] is neither all zeros nor all ones.
REQ-022 product, result and overflow SHALL hold their last values until the next entry to DONE; they SHALL NOT change during RUN.
REQ-023 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-024 start during DONE SHALL be accepted, giving back-to-back operations with no IDLE cycle.
REQ-025 Zero operands SHALL follow the same N-cycle latency, with no early termination.
REQ-026 Inputs whose value is 'x' while not being sampled SHALL NOT affect outputs.

Reset
REQ-027 With rst=0 at a rising edge, the next state SHALL be IDLE, with busy=0, done=0, product=0, result=0, overflow=0, and the accumulator and latched operands cleared.
REQ-028 Reset SHALL take priority over start and SHALL abort a RUN in progress; no done pulse SHALL be produced for the aborted operation.
REQ-029 No output SHALL change asynchronously to clk.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- N=4, unsigned, A=0101, B=0010, start pulse -> done 5 edges later; product=00001010, result=1010, overflow=0; busy=1 for 4 cycles.
- N=4, unsigned, A=1011, B=0010 -> product=00010110, result=0110, overflow=1.
- N=4, signed, A=1001 (-7), B=0101 (5) -> product=11011101 (-35), result=1101, overflow=1.
- N=4, A=1111, B=1111:
  - unsigned -> product=11100001, result=0001, overflow=1.
  - signed (-1*-1) -> product=00000001, overflow=0.
  - signed A=1000, B=1000 -> product=01000000, overflow=1.
- Reset mid-RUN (rst=0 after 2 RUN cycles) -> next cycle busy=0, product=0; no done pulse. Then start with A=0011, B=0011 -> product=00001001 after normal latency.
- Start re-pulsed while busy with different A/B -> ignored, first result unchanged. Start during the DONE cycle -> second operation completes N+1 edges later. N=8 instance, unsigned 255*255 -> product=16'hFE01, overflow=1.
